// File: rtl/led_arb_pkg.sv
// led_arb_pkg: shared state encoding and color field layout for the RGB LED arbiter.
package led_arb_pkg;
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_OWN = 2'd1, ST_SWITCH = 2'd2} state_e;
   localparam int COLOR_W = 24;
   localparam int DUTY_W  = 8;
   localparam int OFS_R   = 16;
   localparam int OFS_G   = 8;
   localparam int OFS_B   = 0;
endpackage

// File: rtl/rgb_pwm.sv
// rgb_pwm: 8-bit three-channel PWM with prescaler and period-aligned shadow color reload.
module rgb_pwm
   import led_arb_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clear,
   input  logic               enable,
   input  logic [COLOR_W-1:0] color_in,
   output logic               led_red,
   output logic               led_green,
   output logic               led_blue
);
   localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
   logic [PW-1:0]      psc_q;
   logic [DUTY_W-1:0]  cnt_q;
   logic [COLOR_W-1:0] shadow_q;
   logic               step;
   assign step = psc_q == PW'(PRESCALE - 1);
   // Shadow only reloads on the 255->0 step so a period never mixes two duties.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         psc_q     <= '0;
         cnt_q     <= '0;
         shadow_q  <= '0;
         led_red   <= 1'b0;
         led_green <= 1'b0;
         led_blue  <= 1'b0;
      end else begin
         if (clear) begin
            psc_q    <= '0;
            cnt_q    <= '0;
            shadow_q <= color_in;
         end else if (enable && step) begin
            psc_q <= '0;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == '1) shadow_q <= color_in;
         end else if (enable) begin
            psc_q <= psc_q + 1'b1;
         end
         led_red   <= enable && (shadow_q[OFS_R +: DUTY_W] > cnt_q);
         led_green <= enable && (shadow_q[OFS_G +: DUTY_W] > cnt_q);
         led_blue  <= enable && (shadow_q[OFS_B +: DUTY_W] > cnt_q);
      end
   end
endmodule

// File: rtl/rgb_led_arbiter.sv
// rgb_led_arbiter: fixed-priority owner selection with minimum hold and a blanking
// cycle between owners, driving the shared RGB LED through rgb_pwm.
module rgb_led_arbiter
   import led_arb_pkg::*;
#(
   parameter int NREQ        = 3,
   parameter int PRESCALE    = 1,
   parameter int HOLD_CYCLES = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req,
   input  logic [COLOR_W*NREQ-1:0] color,
   output logic [NREQ-1:0]         grant,
   output logic                    busy,
   output logic                    led_red,
   output logic                    led_green,
   output logic                    led_blue
);
   localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
   localparam int HW = HOLD_CYCLES > 0 ? $clog2(HOLD_CYCLES + 1) : 1;
   state_e         state_q, state_d;
   logic [IW-1:0]  owner_q, owner_d, top_idx;
   logic [HW-1:0]  hold_q, hold_d;
   logic [NREQ-1:0] grant_d;
   logic           any_req, higher, clear;
   always_comb begin
      top_idx = '0;
      higher  = 1'b0;
      for (int i = NREQ - 1; i >= 0; i--) if (req[i]) top_idx = IW'(i);
      for (int i = 0; i < NREQ; i++) if (req[i] && i < int'(owner_q)) higher = 1'b1;
      any_req = |req;
   end
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      grant_d = grant;
      hold_d  = hold_q == '0 ? hold_q : hold_q - 1'b1;
      clear   = 1'b0;
      if (state_q != ST_OWN) begin
         state_d = any_req ? ST_OWN : ST_IDLE;
         owner_d = any_req ? top_idx : owner_q;
         grant_d = any_req ? NREQ'(1) << top_idx : '0;
         hold_d  = HW'(HOLD_CYCLES);
         clear   = any_req;
      end else if (!req[owner_q] || (hold_q == '0 && higher)) begin
         // An owner drop wins over preemption; the next grant re-arbitrates anyway.
         state_d = ST_SWITCH;
         grant_d = '0;
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         owner_q <= '0;
         hold_q  <= '0;
         grant   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         hold_q  <= hold_d;
         grant   <= grant_d;
      end
   end
   assign busy = state_q != ST_IDLE;
   rgb_pwm #(.PRESCALE(PRESCALE)) u_pwm (
      .clk      (clk),
      .reset    (reset),
      .clear    (clear),
      .enable   (state_q == ST_OWN),
      .color_in (color[COLOR_W*int'(owner_d) +: COLOR_W]),
      .led_red  (led_red),
      .led_green(led_green),
      .led_blue (led_blue)
   );
endmodule

// File: tb/tb_rgb_led_arbiter.sv
// tb_rgb_led_arbiter: vector table, directed corner sequences and a random run
// against a behavioural model of the arbiter and PWM.
module tb_rgb_led_arbiter;
   localparam int HOLD = 8;
   logic        clk, reset;
   logic [2:0]  req, grant;
   logic [71:0] color;
   logic        busy, led_red, led_green, led_blue;
   int checks = 0, errors = 0;

   rgb_led_arbiter #(.NREQ(3), .PRESCALE(1), .HOLD_CYCLES(HOLD)) dut (
      .clk(clk), .reset(reset), .req(req), .color(color), .grant(grant),
      .busy(busy), .led_red(led_red), .led_green(led_green), .led_blue(led_blue)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] req;
      logic [2:0] grant;
      logic       busy;
   } vec_t;
   vec_t tbl[13];

   // model: ms 0=no owner, 1=owned, 2=blanking gap
   int ms, mown, mhold, mcnt;
   int msh[3];
   logic [2:0] mled;
   bit use_model = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int lowest(input logic [2:0] r);
      for (int i = 0; i < 3; i++) if (r[i]) return i;
      return -1;
   endfunction

   function automatic int duty(input int who, input int ch);
      logic [23:0] c;
      c = color[24*who +: 24];
      return int'(c[16-8*ch +: 8]);
   endfunction

   task automatic model_reset();
      ms = 0; mown = 0; mhold = 0; mcnt = 0; mled = 3'b000;
      for (int c = 0; c < 3; c++) msh[c] = 0;
   endtask

   task automatic model_step();
      int lo;
      bit was_own, enter;
      lo = lowest(req);
      was_own = ms == 1;
      enter = 0;
      for (int c = 0; c < 3; c++) mled[2-c] = was_own && msh[c] > mcnt;
      if (!was_own) begin
         if (lo >= 0) begin ms = 1; mown = lo; mhold = HOLD; enter = 1; end
         else ms = 0;
      end else if (!req[mown] || (mhold == 0 && lo >= 0 && lo < mown)) ms = 2;
      else mhold = mhold > 0 ? mhold - 1 : 0;
      if (enter) begin
         mcnt = 0;
         for (int c = 0; c < 3; c++) msh[c] = duty(mown, c);
      end else if (was_own) begin
         if (mcnt == 255) for (int c = 0; c < 3; c++) msh[c] = duty(mown, c);
         mcnt = (mcnt + 1) % 256;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (use_model) model_step();
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req = 3'b000;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      model_reset();
   endtask

   initial begin
      int r_cnt, g_cnt, b_cnt, bad;
      tbl[0]  = '{3'b000, 3'b000, 1'b0};
      tbl[1]  = '{3'b010, 3'b010, 1'b1};
      tbl[2]  = '{3'b010, 3'b010, 1'b1};
      tbl[3]  = '{3'b000, 3'b000, 1'b1};
      tbl[4]  = '{3'b000, 3'b000, 1'b0};
      tbl[5]  = '{3'b110, 3'b010, 1'b1};
      tbl[6]  = '{3'b111, 3'b010, 1'b1};
      tbl[7]  = '{3'b101, 3'b000, 1'b1};
      tbl[8]  = '{3'b101, 3'b001, 1'b1};
      tbl[9]  = '{3'b100, 3'b000, 1'b1};
      tbl[10] = '{3'b100, 3'b100, 1'b1};
      tbl[11] = '{3'b000, 3'b000, 1'b1};
      tbl[12] = '{3'b000, 3'b000, 1'b0};
      color = '0;
      reset = 1'b0;
      req = 3'b000;
      #2;
      do_reset();

      bad = 0;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (grant !== 3'b000 || busy !== 1'b0 || {led_red, led_green, led_blue} !== 3'b000) bad++;
      end
      chk("idle_300", bad, 0);

      for (int i = 0; i < 13; i++) begin
         req = tbl[i].req;
         tick();
         chk($sformatf("vec%0d_grant", i), grant, tbl[i].grant);
         chk($sformatf("vec%0d_busy", i), busy, tbl[i].busy);
      end

      do_reset();
      color[24 +: 24] = 24'h8000FF;
      req = 3'b010;
      tick();
      chk("pwm_grant", grant, 3'b010);
      r_cnt = 0; g_cnt = 0; b_cnt = 0;
      for (int k = 0; k < 256; k++) begin
         tick();
         r_cnt += int'(led_red); g_cnt += int'(led_green); b_cnt += int'(led_blue);
      end
      chk("pwm_red", r_cnt, 128);
      chk("pwm_green", g_cnt, 0);
      chk("pwm_blue", b_cnt, 255);

      do_reset();
      req = 3'b100;
      tick();
      chk("pre_grant", grant, 3'b100);
      tick();
      tick();
      req = 3'b101;
      for (int k = 3; k <= 8; k++) begin
         tick();
         chk($sformatf("pre_hold%0d", k), grant, 3'b100);
      end
      tick();
      chk("pre_gap_grant", grant, 3'b000);
      chk("pre_gap_busy", busy, 1'b1);
      tick();
      chk("pre_new_grant", grant, 3'b001);

      do_reset();
      req = 3'b001;
      tick();
      chk("low_grant", grant, 3'b001);
      req = 3'b011;
      bad = 0;
      for (int k = 0; k < 1000; k++) begin
         tick();
         if (grant !== 3'b001) bad++;
      end
      chk("low_no_preempt", bad, 0);
      req = 3'b010;
      tick();
      chk("low_gap_grant", grant, 3'b000);
      chk("low_gap_busy", busy, 1'b1);
      tick();
      chk("low_new_grant", grant, 3'b010);

      do_reset();
      color[0 +: 24] = 24'h400000;
      req = 3'b001;
      tick();
      r_cnt = 0;
      for (int k = 1; k <= 256; k++) begin
         tick();
         r_cnt += int'(led_red);
         if (k == 100) color[0 +: 24] = 24'hC00000;
      end
      chk("shadow_cur", r_cnt, 64);
      r_cnt = 0;
      for (int k = 0; k < 256; k++) begin
         tick();
         r_cnt += int'(led_red);
      end
      chk("shadow_next", r_cnt, 192);

      #2 reset = 1'b1;
      #1;
      chk("async_rst_grant", grant, 3'b000);
      chk("async_rst_busy", busy, 1'b0);
      chk("async_rst_leds", {led_red, led_green, led_blue}, 3'b000);
      #2 reset = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_regrant", grant, 3'b001);
      chk("rst_regrant_busy", busy, 1'b1);

      do_reset();
      use_model = 1;
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(7) == 0) req[$urandom_range(2)] ^= 1'b1;
         if ($urandom_range(15) == 0) color[24*$urandom_range(2) +: 24] = 24'($urandom);
         tick();
         chk("rand_grant", grant, ms == 1 ? 3'(1 << mown) : 3'b000);
         chk("rand_busy", busy, ms != 0);
         chk("rand_leds", {led_red, led_green, led_blue}, mled);
      end
      use_model = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/rgb_led_arbiter.md
# rgb_led_arbiter

Shares the board's single RGB LED between `NREQ` requesters (e.g. heartbeat blinker, error indicator, user pattern) and drives it with 8-bit-per-channel PWM. Requests use fixed priority, and a minimum hold time prevents flicker from rapid preemption. A one-cycle blanking gap separates successive owners. The block sits between the pattern generators and the top-level `led_red`/`led_green`/`led_blue` pins, replacing direct LED drive.

## Interface
- `NREQ`, 3: number of requesters; index 0 has the highest priority.
- `PRESCALE`, 1: number of clk cycles per PWM count step; must be ≥ 1.
- `HOLD_CYCLES`, 8: minimum number of clk cycles an owner keeps the LED before it can be preempted; 0 allows immediate preemption.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  NREQ  level request, one bit per requester.
- `color`  in  24*NREQ  per-requester `{r[7:0],g[7:0],b[7:0]}`; requester i occupies bits `[24*i+23:24*i]`.
- `grant`  out  NREQ  one-hot current owner; all zero when no requester owns the LED.
- `busy`  out  1  high in states OWN and SWITCH.
- `led_red`, `led_green`, `led_blue`  out  1 each  active-high PWM outputs.

## Operation
- FSM states: IDLE, OWN, SWITCH.
- IDLE: when any `req` bit is high, go to OWN with the highest-priority requester as owner.
- Entering OWN:
  - set `grant` one-hot;
  - load the shadow color from `color[owner]`;
  - clear `pwm_cnt` and the prescaler;
  - load `hold_cnt` with `HOLD_CYCLES`.
- OWN: `hold_cnt` decrements each cycle and saturates at 0.
- OWN → SWITCH when either:
  - `req[owner]` drops (immediate, regardless of `hold_cnt`), or
  - `hold_cnt==0` and a higher-priority `req` bit is high.
- A lower-priority request never preempts the current owner.
- SWITCH lasts exactly 1 cycle with `grant` = 0. It then goes to OWN for the highest-priority pending request, or to IDLE if no request is pending.
- PWM:
  - The prescaler counts 0..PRESCALE-1; `pwm_cnt` (8 bits) increments on prescaler terminal count and wraps 255 → 0.
  - Each LED output is a registered value: `state==OWN && shadow_x > pwm_cnt`.
  - Duty 0 gives always off; duty 255 gives 255 of 256 steps on.
- Shadow reload: the shadow color reloads from `color[owner]` only on the step where `pwm_cnt` wraps 255 → 0. Color changes mid-period therefore take effect at the next period boundary, with no glitch.
- Simultaneous events:
  - Owner drop and higher-priority request in the same cycle: take the drop path to SWITCH; the higher-priority request wins the next grant.
  - Multiple new requests in IDLE or SWITCH: the lowest index wins.

## Timing
- Reset values: state = IDLE; `grant`, `busy`, all LED outputs, `pwm_cnt`, prescaler, `hold_cnt` and shadow = 0. Reset takes effect immediately, including mid-OWN.
- `req` high in IDLE at edge N: `grant` and `busy` are valid after edge N+1.
  - First LED output update is after edge N+2, with `pwm_cnt` = 0.
- Owner drop sampled at edge N:
  - SWITCH after edge N+1: `grant` = 0, `busy` = 1.
  - LEDs are 0 after edge N+2.
  - New grant after edge N+2.
- Preemption: the earliest new grant comes `HOLD_CYCLES + 2` cycles after the original grant (`hold_cnt` expiry, then the SWITCH cycle).
- PWM period = 256 × `PRESCALE` clk cycles.

## Structure
- Package `led_arb_pkg` holds:
  - state encoding (IDLE=0, OWN=1, SWITCH=2);
  - `COLOR_W`=24, `DUTY_W`=8;
  - channel offsets R=16, G=8, B=0.
- Sub-module `rgb_pwm` contains the prescaler, `pwm_cnt`, shadow registers with wrap reload, and registered comparators. Its ports are: `clk`, `reset`, `clear`, `enable`, `color_in`, and the three LED outputs.
- The arbiter FSM, hold counter and priority encoder live in `rgb_led_arbiter`.

## Test plan
All scenarios use `PRESCALE`=1 and `HOLD_CYCLES`=8 unless noted.
- Reset pulse from power-up, no requests → `grant`=0, `busy`=0 and all LEDs 0 for 300 cycles.
- `req`=3'b010 with color[1]=24'h8000FF → `grant`=3'b010 one cycle later. Over one 256-cycle period: `led_red` high 128 cycles, `led_green` 0 cycles, `led_blue` 255 cycles.
- `req[2]` owns, then `req[0]` rises 2 cycles after the grant → `grant` stays 3'b100 until `hold_cnt` expires, then 1 cycle of 0, then 3'b001 at grant+10.
- `req[0]` owns, then `req[1]` rises → no change for 1000 cycles. Drop `req[0]` → 1 SWITCH cycle, then `grant`=3'b010.
- Owner color changes from R=8'h40 to 8'hC0 at `pwm_cnt`=100 → current period shows 64 high cycles; the next period shows 192.
- Assert `reset` mid-OWN between clock edges → `grant`, `busy` and all LEDs drop to 0 before the next edge. After `reset` releases with the request still high, a grant is reissued one cycle later.
